// File: rtl/instr_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// FSM state encoding and the NOP word returned on a miss.
package instr_cache_pkg;

  localparam int DEF_ADDRESS_WIDTH  = 32;
  localparam int DEF_INSTR_WIDTH    = 32;
  localparam int DEF_LINES          = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

  // Instructions are 4 bytes, so the two lowest PC bits never select anything.
  localparam int BYTE_OFFSET_BITS = 2;

  localparam int unsigned NOP_VALUE = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  function automatic int offset_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int address_width, input int lines, input int words_per_line);
    return address_width - index_bits(lines) - offset_bits(words_per_line) - BYTE_OFFSET_BITS;
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Fetch-side lookup and memory-side refill signals of the instruction cache.
// The cache uses the slave modport; the fetch stage / memory backplane use master.
interface instr_cache_if
  import instr_cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int INSTR_WIDTH   = DEF_INSTR_WIDTH
);

  logic [ADDRESS_WIDTH-1:0] i_PCF;
  logic                     i_ReqF;
  logic                     i_Flush;
  logic [INSTR_WIDTH-1:0]   o_InstrF;
  logic                     o_HitF;
  logic                     o_StallF;
  logic                     o_MemReq;
  logic [ADDRESS_WIDTH-1:0] o_MemAddr;
  logic                     i_MemReady;
  logic [INSTR_WIDTH-1:0]   i_MemData;

  modport slave (
    input  i_PCF, i_ReqF, i_Flush, i_MemReady, i_MemData,
    output o_InstrF, o_HitF, o_StallF, o_MemReq, o_MemAddr
  );

  modport master (
    output i_PCF, i_ReqF, i_Flush, i_MemReady, i_MemData,
    input  o_InstrF, o_HitF, o_StallF, o_MemReq, o_MemAddr
  );

endinterface

// File: rtl/instr_cache_data_array.sv
// Instruction storage: LINES x WORDS_PER_LINE words, asynchronous read for the
// zero-latency hit path and one synchronous write port used by refills.
module instr_cache_data_array
  import instr_cache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int INSTR_WIDTH    = DEF_INSTR_WIDTH,
  localparam int INDEX_BITS    = index_bits(LINES),
  localparam int OFFSET_BITS   = offset_bits(WORDS_PER_LINE)
) (
  input  logic                   clk,
  input  logic [INDEX_BITS-1:0]  rd_index,
  input  logic [OFFSET_BITS-1:0] rd_word,
  output logic [INSTR_WIDTH-1:0] rd_data,
  input  logic                   we,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [OFFSET_BITS-1:0] wr_word,
  input  logic [INSTR_WIDTH-1:0] wr_data
);

  logic [INSTR_WIDTH-1:0] mem_q [LINES][WORDS_PER_LINE];

  // Contents are deliberately never reset; the valid bits in the top qualify them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_index][wr_word] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_index][rd_word];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, and a
// line refill from memory (words in order 0..N-1) that stalls fetch on a miss.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int INSTR_WIDTH    = DEF_INSTR_WIDTH,
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input logic          i_CLK,
  input logic          i_RST,
  instr_cache_if.slave bus
);

  localparam int OFFSET_BITS = offset_bits(WORDS_PER_LINE);
  localparam int INDEX_BITS  = index_bits(LINES);
  localparam int TAG_BITS    = tag_bits(ADDRESS_WIDTH, LINES, WORDS_PER_LINE);
  localparam int LINE_BITS   = TAG_BITS + INDEX_BITS;
  localparam logic [OFFSET_BITS-1:0] LAST_BEAT = OFFSET_BITS'(WORDS_PER_LINE - 1);
  localparam logic [INSTR_WIDTH-1:0] NOP       = INSTR_WIDTH'(NOP_VALUE);

  state_t                 state_q, state_d;
  logic [OFFSET_BITS-1:0] beat_q, beat_d;
  logic                   discard_q, discard_d;
  logic [LINE_BITS-1:0]   line_q, line_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_BITS-1:0]    tag_q [LINES];

  logic [TAG_BITS-1:0]    pc_tag;
  logic [INDEX_BITS-1:0]  pc_index;
  logic [OFFSET_BITS-1:0] pc_offset;
  logic [INDEX_BITS-1:0]  refill_index;
  logic [TAG_BITS-1:0]    refill_tag;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   data_we;
  logic                   tag_we;
  logic                   unused_pc_bits;

  assign pc_tag         = bus.i_PCF[ADDRESS_WIDTH-1 -: TAG_BITS];
  assign pc_index       = bus.i_PCF[BYTE_OFFSET_BITS+OFFSET_BITS +: INDEX_BITS];
  assign pc_offset      = bus.i_PCF[BYTE_OFFSET_BITS +: OFFSET_BITS];
  assign unused_pc_bits = ^bus.i_PCF[BYTE_OFFSET_BITS-1:0];

  // line_q holds {tag,index} of the line in flight, so it survives PC redirects.
  assign refill_index = line_q[INDEX_BITS-1:0];
  assign refill_tag   = line_q[LINE_BITS-1 -: TAG_BITS];

  instr_cache_data_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .INSTR_WIDTH    (INSTR_WIDTH)
  ) u_data_array (
    .clk      (i_CLK),
    .rd_index (pc_index),
    .rd_word  (pc_offset),
    .rd_data  (rd_data),
    .we       (data_we),
    .wr_index (refill_index),
    .wr_word  (beat_q),
    .wr_data  (bus.i_MemData)
  );

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      discard_q <= 1'b0;
      line_q    <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      discard_q <= discard_d;
      line_q    <= line_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (tag_we) begin
      tag_q[refill_index] <= refill_tag;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    discard_d     = discard_q;
    line_d        = line_q;
    valid_d       = valid_q;
    data_we       = 1'b0;
    tag_we        = 1'b0;
    bus.o_HitF    = 1'b0;
    bus.o_InstrF  = NOP;
    bus.o_StallF  = 1'b0;
    bus.o_MemReq  = 1'b0;
    bus.o_MemAddr = '0;

    if (bus.i_Flush) begin
      valid_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.i_ReqF) begin
          if (valid_q[pc_index] && (tag_q[pc_index] == pc_tag)) begin
            bus.o_HitF   = 1'b1;
            bus.o_InstrF = rd_data;
          end else begin
            bus.o_StallF = 1'b1;
            line_d       = {pc_tag, pc_index};
            state_d      = REFILL;
          end
        end
      end

      REFILL: begin
        bus.o_StallF  = 1'b1;
        bus.o_MemReq  = 1'b1;
        bus.o_MemAddr = {line_q, beat_q, {BYTE_OFFSET_BITS{1'b0}}};
        if (bus.i_Flush) begin
          discard_d = 1'b1;
        end
        if (bus.i_MemReady) begin
          data_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            // A flush on this same edge has already cleared every valid bit.
            tag_we    = 1'b1;
            if (!bus.i_Flush) begin
              valid_d[refill_index] = ~discard_q;
            end
            discard_d = 1'b0;
            beat_d    = '0;
            state_d   = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: directed fetches push expected instructions
// and refill beat addresses; a negedge monitor pops and compares them.
module tb_instr_cache;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  instr_cache_if #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  instr_cache #(
    .ADDRESS_WIDTH  (32),
    .INSTR_WIDTH    (32),
    .LINES          (16),
    .WORDS_PER_LINE (4)
  ) dut (
    .i_CLK (clk),
    .i_RST (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_instr [$];
  logic [31:0] exp_addr  [$];
  bit          mon_en   = 1'b0;
  int          ready_delay = 0;
  int          wait_cnt    = 0;

  // Backing memory: word at byte address a reads as 0xC0DE0000 | a[15:0].
  assign bus.i_MemData = 32'hC0DE_0000 | {16'h0000, bus.o_MemAddr[15:0]};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int w = 0; w < 4; w++) exp_addr.push_back(base + 32'(4 * w));
  endtask

  // Memory responder: ready after ready_delay idle cycles of each requested beat.
  initial begin
    bus.i_MemReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_MemReq) begin
        if (wait_cnt >= ready_delay) begin
          bus.i_MemReady = 1'b1;
          wait_cnt = 0;
        end else begin
          bus.i_MemReady = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.i_MemReady = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: hits consume expected instructions; refill address must match the
  // queue head every cycle it is requested and advances when the beat completes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_HitF) begin
        if (exp_instr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_hit: got instr 0x%08h with no expected entry", bus.o_InstrF);
        end else begin
          check_output("hit_instr", bus.o_InstrF, exp_instr.pop_front());
        end
      end else begin
        check_output("nop_on_no_hit", bus.o_InstrF, 32'h0);
      end
      if (bus.o_MemReq) begin
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_mem_req: got addr 0x%08h with no expected entry", bus.o_MemAddr);
        end else begin
          check_output("mem_addr", bus.o_MemAddr, exp_addr[0]);
          if (bus.i_MemReady) void'(exp_addr.pop_front());
        end
      end
    end
  end

  // Issue one fetch starting just after a posedge; returns just after the posedge
  // that follows the hit cycle, having counted stall cycles on the way.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] instr,
                                input int exp_stalls, input string name);
    int stalls = 0;
    bit got    = 1'b0;
    exp_instr.push_back(instr);
    bus.i_PCF  = addr;
    bus.i_ReqF = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (bus.o_HitF) got = 1'b1;
      else if (bus.o_StallF) stalls++;
      @(posedge clk);
      #1;
    end
    bus.i_ReqF = 1'b0;
    check_output({name, "_hit_seen"}, 32'(got), 32'd1);
    check_output({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.i_PCF      = 32'h0;
    bus.i_ReqF     = 1'b0;
    bus.i_Flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_hit", 32'(bus.o_HitF), 32'd0);
    check_output("reset_stall", 32'(bus.o_StallF), 32'd0);
    check_output("reset_memreq", 32'(bus.o_MemReq), 32'd0);
    check_output("reset_memaddr", bus.o_MemAddr, 32'h0);
    check_output("reset_instr", bus.o_InstrF, 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    $display("[TB] cold miss on 0x0");
    push_line(32'h0000_0000);
    apply_stimulus(32'h0000_0000, 32'hC0DE_0000, 5, "cold_0x0");

    $display("[TB] back-to-back hits in line 0");
    apply_stimulus(32'h0000_0004, 32'hC0DE_0004, 0, "hit_0x4");
    apply_stimulus(32'h0000_0008, 32'hC0DE_0008, 0, "hit_0x8");
    apply_stimulus(32'h0000_000C, 32'hC0DE_000C, 0, "hit_0xC");

    $display("[TB] conflict miss on index 0");
    push_line(32'h0000_0100);
    apply_stimulus(32'h0000_0100, 32'hC0DE_0100, 5, "conflict_0x100");
    push_line(32'h0000_0000);
    apply_stimulus(32'h0000_0000, 32'hC0DE_0000, 5, "evicted_0x0");

    $display("[TB] slow memory refill of 0x20");
    ready_delay = 3;
    push_line(32'h0000_0020);
    apply_stimulus(32'h0000_0024, 32'hC0DE_0024, 17, "slow_0x24");
    ready_delay = 0;

    $display("[TB] flush during beat 2 of refill 0x40");
    push_line(32'h0000_0040);
    push_line(32'h0000_0040);
    fork
      apply_stimulus(32'h0000_0040, 32'hC0DE_0040, 10, "flushed_0x40");
      begin
        bit done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
          @(posedge clk);
          #1;
          if (bus.o_MemReq && bus.o_MemAddr == 32'h0000_0048) begin
            bus.i_Flush = 1'b1;
            @(posedge clk);
            #1;
            bus.i_Flush = 1'b0;
            done = 1'b1;
          end
        end
        check_output("flush_beat2_reached", 32'(done), 32'd1);
      end
    join

    $display("[TB] reset during beat 2 of refill 0x80");
    exp_addr.push_back(32'h0000_0080);
    exp_addr.push_back(32'h0000_0084);
    exp_addr.push_back(32'h0000_0088);
    bus.i_PCF  = 32'h0000_0080;
    bus.i_ReqF = 1'b1;
    begin
      bit done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
        @(posedge clk);
        #1;
        if (bus.o_MemReq && bus.o_MemAddr == 32'h0000_0088) begin
          rst_n      = 1'b0;
          bus.i_ReqF = 1'b0;
          done       = 1'b1;
        end
      end
      check_output("reset_beat2_reached", 32'(done), 32'd1);
    end
    @(posedge clk);
    #1;
    check_output("midreset_memreq", 32'(bus.o_MemReq), 32'd0);
    check_output("midreset_memaddr", bus.o_MemAddr, 32'h0);
    check_output("midreset_stall", 32'(bus.o_StallF), 32'd0);
    rst_n = 1'b1;
    push_line(32'h0000_0040);
    apply_stimulus(32'h0000_004C, 32'hC0DE_004C, 5, "after_reset_0x4C");

    repeat (2) @(posedge clk);
    check_output("instr_queue_drained", 32'(exp_instr.size()), 32'd0);
    check_output("addr_queue_drained", 32'(exp_addr.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
